// File: rtl/soric_bridge_pkg.sv
// Shared constants for the Wishbone-to-req/gnt bridge: FSM encoding and the
// read data returned on a grant timeout.
package soric_bridge_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_WAIT_RV = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  // Read data handed back to the Wishbone master when the grant never arrives
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Width of a saturating counter able to hold the value max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_to_obi_bridge_if.sv
// Bus bundle for the bridge: Wishbone-classic slave side plus the
// req/gnt/rvalid interconnect master side and the timeout flag.
interface wb_to_obi_bridge_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);

  // Wishbone side
  logic                      wbs_stb_i;
  logic                      wbs_cyc_i;
  logic                      wbs_we_i;
  logic [DATA_WIDTH/8-1:0]   wbs_sel_i;
  logic [31:0]               wbs_adr_i;
  logic [DATA_WIDTH-1:0]     wbs_dat_i;
  logic                      wbs_ack_o;
  logic [DATA_WIDTH-1:0]     wbs_dat_o;

  // Interconnect side
  logic                      data_req_o;
  logic [ADDR_WIDTH-1:0]     data_addr_o;
  logic                      data_we_o;
  logic [DATA_WIDTH/8-1:0]   data_be_o;
  logic [DATA_WIDTH-1:0]     data_wdata_o;
  logic                      data_gnt_i;
  logic                      data_rvalid_i;
  logic [DATA_WIDTH-1:0]     data_rdata_i;

  // Abort indication
  logic                      timeout_o;

  // The bridge itself: Wishbone slave, interconnect master
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i,
    output wbs_ack_o, wbs_dat_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output timeout_o
  );

  // The environment: Wishbone master plus interconnect responder
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i,
    input  wbs_ack_o, wbs_dat_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  timeout_o
  );

endinterface

// File: rtl/bridge_timeout_cnt.sv
// Saturating grant-timeout counter. Cleared when a request starts, counts
// every request cycle without a grant, and flags expiry once it has reached
// GNT_TIMEOUT. It never wraps, so a stalled request stays expired.
module bridge_timeout_cnt
  import soric_bridge_pkg::*;
#(
  parameter int GNT_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int                CNT_W   = cnt_width(GNT_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(GNT_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Count request cycles without grant, holding at the limit
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == CNT_MAX);

endmodule

// File: rtl/wb_to_obi_bridge.sv
// Wishbone-classic slave to req/gnt/rvalid master bridge. Each Wishbone
// access is registered, issued as exactly one interconnect request, and
// answered with a single-cycle ack carrying registered read data. A grant
// timeout aborts requests to unmapped or stalled slaves so the management
// core cannot hang. All outputs come straight from flops.
module wb_to_obi_bridge
  import soric_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  wb_to_obi_bridge_if.slave bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_req;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_timeout;

  logic                  w_start;
  logic                  w_in_req;
  logic                  w_expired;
  logic                  w_abort;
  logic                  w_cnt_en;

  // A new access is only taken from IDLE; stb outside IDLE is ignored
  assign w_start  = (r_state == ST_IDLE) & bus.wbs_stb_i & bus.wbs_cyc_i;
  assign w_in_req = (r_state == ST_REQ);
  // Grant wins over an expiry in the same cycle
  assign w_abort  = w_in_req & ~bus.data_gnt_i & w_expired;
  assign w_cnt_en = w_in_req & ~bus.data_gnt_i;

  bridge_timeout_cnt #(
    .GNT_TIMEOUT (GNT_TIMEOUT)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr      (w_start),
    .en       (w_cnt_en),
    .expired  (w_expired)
  );

  // Next-state logic; gnt/rvalid only matter in REQ and WAIT_RV
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.data_gnt_i) begin
          w_state_nxt = bus.data_rvalid_i ? ST_ACK : ST_WAIT_RV;
        end else if (w_expired) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_WAIT_RV: begin
        if (bus.data_rvalid_i) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the Wishbone access; fields stay stable until the next access
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_addr  <= bus.wbs_adr_i[ADDR_WIDTH-1:0];
      r_we    <= bus.wbs_we_i;
      r_be    <= bus.wbs_sel_i;
      r_wdata <= bus.wbs_dat_i;
    end
  end

  // Handshake flags registered from the next state so they align with it
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_req     <= 1'b0;
      r_ack     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_req     <= (w_state_nxt == ST_REQ);
      r_ack     <= (w_state_nxt == ST_ACK);
      r_timeout <= w_abort;
    end
  end

  // Load ack data: abort pattern, zero for writes, else interconnect rdata
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rdata <= '0;
    end else if (w_state_nxt == ST_ACK && r_state != ST_ACK) begin
      if (w_abort) begin
        r_rdata <= DATA_WIDTH'(TIMEOUT_RDATA);
      end else if (r_we) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= bus.data_rdata_i;
      end
    end
  end

  // Upper Wishbone address bits are outside the interconnect window
  generate
    if (ADDR_WIDTH < 32) begin : g_unused_adr
      logic w_unused_adr;
      assign w_unused_adr = ^bus.wbs_adr_i[31:ADDR_WIDTH];
    end
  endgenerate

  assign bus.data_req_o   = r_req;
  assign bus.data_addr_o  = r_addr;
  assign bus.data_we_o    = r_we;
  assign bus.data_be_o    = r_be;
  assign bus.data_wdata_o = r_wdata;
  assign bus.wbs_ack_o    = r_ack;
  assign bus.wbs_dat_o    = r_rdata;
  assign bus.timeout_o    = r_timeout;

endmodule

// File: tb/tb_wb_to_obi_bridge.sv
// Bench for wb_to_obi_bridge: table of Wishbone accesses with interconnect
// response timing, expected ack results queued per access, plus hand-written
// reset, stray-grant and back-to-back sequences.
module tb_wb_to_obi_bridge;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int GTO = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          gnt_dly;   // request cycles before grant, -1 = never
    int          rv_dly;    // cycles from grant to rvalid, 0 = same cycle
    logic [31:0] rdata;
    bit          drop_cyc;  // master drops cyc/stb after acceptance
    bit          stray;     // drive stray gnt/rvalid after the ack
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        to;
    int          ack_cyc;
    int          nreq;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  exp_t sb[$];
  vec_t tbl[11];

  wb_to_obi_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_to_obi_bridge #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .GNT_TIMEOUT (GTO)
  ) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
      n_miss++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(bus.data_req_o),   32'h0);
    chk({tag, "_addr"},  32'(bus.data_addr_o),  32'h0);
    chk({tag, "_we"},    32'(bus.data_we_o),    32'h0);
    chk({tag, "_be"},    32'(bus.data_be_o),    32'h0);
    chk({tag, "_wdata"}, bus.data_wdata_o,      32'h0);
    chk({tag, "_ack"},   32'(bus.wbs_ack_o),    32'h0);
    chk({tag, "_dat"},   bus.wbs_dat_o,         32'h0);
    chk({tag, "_to"},    32'(bus.timeout_o),    32'h0);
  endtask

  // Expected ack result derived from the response timing of the vector
  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    if (v.gnt_dly < 0) begin
      e.dat = 32'hDEAD_BEEF; e.to = 1'b1;
      e.ack_cyc = GTO + 2;   e.nreq = GTO + 1;
    end else begin
      e.dat = v.we ? 32'h0 : v.rdata; e.to = 1'b0;
      e.nreq = v.gnt_dly + 1;
      e.ack_cyc = v.gnt_dly + 2 + v.rv_dly;
    end
    return e;
  endfunction

  task automatic do_access(input vec_t v);
    exp_t e;
    int   cnum;
    int   nreq;
    int   rv_cnt;
    bit   granted;
    bit   done;
    logic [31:0] a;
    @(negedge clk);
    chk("idle_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("idle_req", 32'(bus.data_req_o), 32'h0);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = v.we;
    bus.wbs_adr_i = v.adr; bus.wbs_sel_i = v.sel; bus.wbs_dat_i = v.wdat;
    sb.push_back(exp_of(v));
    n_vec++;
    a = v.adr;
    cnum = 0; nreq = 0; rv_cnt = -1; granted = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cnum++;
      bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = $urandom;
      if (v.drop_cyc && cnum == 1) begin
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
      end
      if (bus.wbs_ack_o) begin
        e = sb.pop_front();
        chk("ack_dat",    bus.wbs_dat_o,        e.dat);
        chk("ack_to",     32'(bus.timeout_o),   32'(e.to));
        chk("ack_cycle",  32'(cnum),            32'(e.ack_cyc));
        chk("req_cycles", 32'(nreq),            32'(e.nreq));
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
        done = 1'b1;
      end else begin
        chk("early_to", 32'(bus.timeout_o), 32'h0);
        if (bus.data_req_o) begin
          nreq++;
          chk("req_addr",  32'(bus.data_addr_o), {18'h0, a[13:0]});
          chk("req_we",    32'(bus.data_we_o),   32'(v.we));
          chk("req_be",    32'(bus.data_be_o),   32'(v.sel));
          chk("req_wdata", bus.data_wdata_o,     v.wdat);
          if (!granted && v.gnt_dly >= 0 && nreq - 1 == v.gnt_dly) begin
            bus.data_gnt_i = 1'b1; granted = 1'b1; rv_cnt = v.rv_dly;
          end
        end
        if (granted && rv_cnt == 0) begin
          bus.data_rvalid_i = 1'b1; bus.data_rdata_i = v.rdata; rv_cnt = -1;
        end else if (rv_cnt > 0) begin
          rv_cnt--;
        end
        if (cnum > 400) begin
          $display("FAIL ack_wait: no ack after %0d cycles, expected by cycle %0d",
                   cnum, sb[0].ack_cyc);
          n_miss++;
          void'(sb.pop_front());
          done = 1'b1;
        end
      end
    end
    if (v.stray) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("stray_ack", 32'(bus.wbs_ack_o),  32'h0);
        chk("stray_req", 32'(bus.data_req_o), 32'h0);
        bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h5555_AAAA;
      end
      @(negedge clk);
      chk("stray_ack", 32'(bus.wbs_ack_o),  32'h0);
      chk("stray_req", 32'(bus.data_req_o), 32'h0);
      bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    //            we    adr            sel    wdat          gnt rv  rdata         drop stray
    tbl[0]  = '{1'b0, 32'h0000_0804, 4'hF, 32'h0,         0,  1, 32'h1234_5678, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_2000, 4'h3, 32'hA5A5_A5A5, 4,  1, 32'hFFFF_0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         0,  0, 32'hCAFE_F00D, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,        -1,  0, 32'h0,         1'b0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         0,  1, 32'h1111_1111, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0104, 4'hF, 32'h0,         0,  1, 32'h2222_2222, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'hFFFF_3FFC, 4'hF, 32'h5A5A_1234, 2,  3, 32'h9999_9999, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0208, 4'hF, 32'h0,         1,  2, 32'h0BAD_C0DE, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0300, 4'hC, 32'h0F0F_0F0F, 0,  0, 32'h7777_7777, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0310, 4'h1, 32'h1234_ABCD,-1,  0, 32'h0,         1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_3FF0, 4'hF, 32'h0,         0,  1, 32'hFEED_FACE, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_vec++;
    rst_n = 1'b1;

    // Reset asserted while a request is outstanding
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h0000_1234; bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = 32'hCAFE_0001;
    @(negedge clk);
    chk("midreq_req", 32'(bus.data_req_o), 32'h1);
    @(negedge clk);
    chk("midreq_req2", 32'(bus.data_req_o), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;

    // Table vectors, issued back to back
    for (int i = 0; i < 11; i++) begin
      do_access(tbl[i]);
    end

    @(negedge clk);
    chk("final_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("final_req", 32'(bus.data_req_o), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
